// File: rtl/noc_pkg.sv
// Shared flit layout and injection-port FSM encoding for the local router port.
package noc_pkg;

    localparam int unsigned FLIT_W    = 20;
    localparam int unsigned PAYLOAD_W = 16;
    localparam int unsigned DST_CL_HI = 19;
    localparam int unsigned DST_CL_LO = 18;
    localparam int unsigned DST_LO_HI = 17;
    localparam int unsigned DST_LO_LO = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSend  = 2'd1,
        StStall = 2'd2
    } inj_state_e;

    function automatic logic [FLIT_W-1:0] pack_flit(
        input logic [1:0]           dst_cluster,
        input logic [1:0]           dst_local,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [FLIT_W-1:0] flit;
        flit = '0;
        flit[DST_CL_HI:DST_CL_LO] = dst_cluster;
        flit[DST_LO_HI:DST_LO_LO] = dst_local;
        flit[PAYLOAD_W-1:0]       = payload;
        return flit;
    endfunction

endpackage

// File: rtl/inj_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module inj_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = mem[rd_ptr_q[AW-1:0]];

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pe_inject_port.sv
// PE-to-router injection port: buffers requests, packs flits and sends them under
// credit-based flow control toward router input port 5.
module pe_inject_port
    import noc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned RTR_CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        my_cluster,
    input  logic [1:0]        my_local,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_dst_cluster,
    input  logic [1:0]        req_dst_local,
    input  logic [15:0]       req_data,
    input  logic              ci,
    output logic [FLIT_W-1:0] dataout,
    output logic              out_valid,
    output logic              busy,
    output logic              self_drop,
    output logic              credit_err,
    output logic [15:0]       sent_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(RTR_CREDITS + 1);

    localparam logic [CW-1:0] CreditMax = CW'(RTR_CREDITS);
    localparam logic [CW-1:0] CreditOne = CW'(1);
    localparam logic [LW-1:0] LevelOne  = LW'(1);

    logic [FLIT_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic [LW-1:0]     level_nxt;

    logic              is_self;
    logic              accept;
    logic              push;
    logic              send;

    logic [CW-1:0]     credits_q, credits_d;
    logic              credit_err_q, credit_err_d;
    inj_state_e        state_q, state_d;
    logic [FLIT_W-1:0] dataout_q;
    logic              out_valid_q;
    logic              self_drop_q;
    logic [15:0]       sent_count_q;

    assign is_self   = (req_dst_cluster == my_cluster) && (req_dst_local == my_local);
    assign req_ready = rst && !fifo_full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && !is_self;
    assign send      = !fifo_empty && (credits_q != '0);

    inj_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (send),
        .wdata (pack_flit(req_dst_cluster, req_dst_local, req_data)),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        level_nxt = fifo_level;
        if (push) begin
            level_nxt = level_nxt + LevelOne;
        end
        if (send) begin
            level_nxt = level_nxt - LevelOne;
        end
    end

    // Send and return in the same cycle cancel; a return at full credit is a protocol error.
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (send && !ci) begin
            credits_d = credits_q - CreditOne;
        end else if (ci && !send) begin
            if (credits_q == CreditMax) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CreditOne;
            end
        end
    end

    // State follows the post-edge FIFO occupancy and credit count.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (level_nxt != '0) begin
                    state_d = (credits_d != '0) ? StSend : StStall;
                end
            end
            StSend: begin
                if (level_nxt == '0) begin
                    state_d = StIdle;
                end else if (credits_d == '0) begin
                    state_d = StStall;
                end
            end
            StStall: begin
                if (level_nxt == '0) begin
                    state_d = StIdle;
                end else if (credits_d != '0) begin
                    state_d = StSend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            credits_q    <= CreditMax;
            credit_err_q <= 1'b0;
            dataout_q    <= '0;
            out_valid_q  <= 1'b0;
            self_drop_q  <= 1'b0;
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
            out_valid_q  <= send;
            self_drop_q  <= accept && is_self;
            if (send) begin
                dataout_q    <= fifo_rdata;
                sent_count_q <= sent_count_q + 16'd1;
            end
        end
    end

    assign dataout    = dataout_q;
    assign out_valid  = out_valid_q;
    assign self_drop  = self_drop_q;
    assign credit_err = credit_err_q;
    assign sent_count = sent_count_q;
    assign busy       = !fifo_empty || (state_q != StIdle);

endmodule
